rfdc_adc_integrator: RTL and testbench
======================================

// Module: rfdc_adc_integrator
// PURPOSE
//  Receive-side counterpart of the RFDC DAC sample path. Consumes the 256-bit ADC stream
//  (16 lanes x 16-bit signed samples per clk), subtracts a DC offset and integrates all lanes
//  over a timestamp-scheduled window. Emits one 64-bit result per window to the capture FIFO.
// PARAMETERS
//  LANES     16  samples per beat; tdata width = LANES*SAMPLE_W
//  SAMPLE_W  16  signed sample width
//  ACC_W     48  signed accumulator width, 24..63
// PORTS
//  clk                 in   1    system clock, single domain
//  resetn              in   1    asynchronous, active-low reset
//  s_axis_data_tdata   in   256  ADC lanes; lane i = [16*i +: 16], signed
//  s_axis_data_tvalid  in   1    beat valid
//  s_axis_data_tready  out  1    always 1 outside reset; the ADC stream is never stalled
//  timestamp           in   64   global time counter, +1 per clk
//  start_time          in   64   timestamp of the first integrated beat, sampled on arm
//  window_len          in   32   beats to integrate, sampled on arm; 0 is treated as 1
//  amp_offset          in   16   signed offset subtracted from every sample, sampled on arm
//  arm                 in   1    1-cycle request; honoured only in IDLE
//  busy                out  1    1 in every state except IDLE
//  err_late            out  1    sticky; cleared by an accepted arm
//  res_tdata           out  64   sign-extended accumulator
//  res_tuser           out  2    {drop, sat}
//  res_tvalid          out  1    result valid
//  res_tready          in   1    result accept
// BEHAVIOUR
//  Reset: state IDLE; busy, err_late, res_tvalid, res_tdata, res_tuser, accumulator = 0;
//   s_axis_data_tready = 0 while resetn = 0, then 1 from the first clk after release.
//   Reset mid-window discards the window; no partial result is produced.
//  Datapath, 3 register stages:
//   S1: per lane, sample - offset as a 17-bit signed value; invalid beats are forced to 0.
//   S2: adder tree over all lanes, 21-bit signed result.
//   S3: acc <= acc + sext(S2) during ACCUM/DRAIN.
//   Saturation: result is clamped to +/-(2^(ACC_W-1)) limits (max 2^(ACC_W-1)-1); sat set, sticky.
//  FSM:
//   IDLE:   on arm, latch start_time/window_len/amp_offset, clear acc/sat/drop/err_late.
//           If start_time <= timestamp: set err_late, stay IDLE. Otherwise go ARMED.
//   ARMED:  when timestamp == latched start_time, that beat is beat 0; go ACCUM; cnt = 1.
//   ACCUM:  one beat counted per clk. If tvalid = 0 on a counted beat: contributes 0, drop set.
//           After window_len beats go DRAIN.
//   DRAIN:  2 cycles for pipeline flush; then OUTPUT.
//   OUTPUT: res_tvalid = 1 with res_tdata/res_tuser held stable until res_tready.
//           On handshake: res_tvalid = 0 and state IDLE on the next clk.
//  Latency: last beat at timestamp start+W-1; res_tvalid first high in the cycle timestamp == start+W+2.
//  arm outside IDLE: ignored, no flag. arm in the handshake cycle: ignored.
//  A timestamp wrap between arm and start is not supported; software guarantees no wrap.
//  Counters: cnt is 32-bit, compared to max(window_len,1); no wrap within a window.
// TESTING
//  1 All lanes 0x0100, offset 0, start = now+10, W = 4 -> res_tdata = 0x4000, tuser = 0,
//    res_tvalid at timestamp start+6.
//  2 Lanes 0x0000, offset 0x0010, W = 1 -> res_tdata = 0xFFFF_FFFF_FFFF_FF00.
//  3 ACC_W = 24, lanes 0x7FFF, W = 20 -> res_tdata = 0x7F_FFFF, sat = 1.
//  4 arm with start = timestamp-1 -> err_late = 1, busy stays 0, no result;
//    a later valid arm clears err_late.
//  5 W = 8, lanes 0x0001, tvalid low for 2 beats -> res_tdata = 96, drop = 1.
//  6 res_tready low 5 cycles with arm pulses -> data stable, arm ignored, busy = 1;
//    after handshake busy = 0. resetn low mid-ACCUM -> all outputs 0, no result.

Source files
------------

// File: rtl/rfdc_adc_integrator.sv
// rfdc_adc_integrator: offset-corrected, timestamp-windowed integration of a 16-lane ADC stream.
// Three-stage datapath (lane diff, adder tree, saturating accumulate) driven by a window FSM.
module rfdc_adc_integrator #(
  parameter int LANES    = 16,
  parameter int SAMPLE_W = 16,
  parameter int ACC_W    = 48
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [LANES*SAMPLE_W-1:0] s_axis_data_tdata,
  input  logic                      s_axis_data_tvalid,
  output logic                      s_axis_data_tready,
  input  logic [63:0]               timestamp,
  input  logic [63:0]               start_time,
  input  logic [31:0]               window_len,
  input  logic [15:0]               amp_offset,
  input  logic                      arm,
  output logic                      busy,
  output logic                      err_late,
  output logic [63:0]               res_tdata,
  output logic [1:0]                res_tuser,
  output logic                      res_tvalid,
  input  logic                      res_tready
);
  localparam int D_W   = SAMPLE_W + 1;
  localparam int SUM_W = D_W + $clog2(LANES);

  typedef enum logic [2:0] {IDLE, ARMED, ACCUM, DRAIN, OUTPUT} state_t;

  state_t                    state, nxt;
  logic [63:0]               start_q;
  logic [31:0]               wl_q, cnt;
  logic signed [SAMPLE_W-1:0] off_q;
  logic                      dcnt, sat, drop, tready_q;
  logic signed [D_W-1:0]     s1 [LANES];
  logic signed [D_W-1:0]     d1 [LANES];
  logic signed [SUM_W-1:0]   s2, sum;
  logic signed [ACC_W-1:0]   acc, acc_nxt;
  logic signed [ACC_W:0]     acc_sum;
  logic                      arm_ok, counting, ovf;

  assign arm_ok   = (state == IDLE) && arm;
  assign counting = ((state == ARMED) && (timestamp == start_q)) || (state == ACCUM);

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = (arm && start_time > timestamp) ? ARMED : IDLE;
      ARMED:   nxt = (timestamp == start_q) ? ((wl_q == 32'd1) ? DRAIN : ACCUM) : ARMED;
      ACCUM:   nxt = (cnt + 32'd1 == wl_q) ? DRAIN : ACCUM;
      DRAIN:   nxt = dcnt ? OUTPUT : DRAIN;
      OUTPUT:  nxt = res_tready ? IDLE : OUTPUT;
      default: nxt = IDLE;
    endcase
  end

  // Beats outside the window and invalid beats in it both enter the pipe as zero.
  always_comb begin
    for (int i = 0; i < LANES; i++)
      d1[i] = (counting && s_axis_data_tvalid)
            ? D_W'($signed(s_axis_data_tdata[SAMPLE_W*i +: SAMPLE_W])) - D_W'(off_q) : '0;
    sum = '0;
    for (int i = 0; i < LANES; i++)
      sum = sum + SUM_W'(s1[i]);
    acc_sum = (ACC_W+1)'(acc) + (ACC_W+1)'(s2);
    ovf     = acc_sum[ACC_W] ^ acc_sum[ACC_W-1];
    acc_nxt = ovf ? {acc_sum[ACC_W], {(ACC_W-1){~acc_sum[ACC_W]}}} : acc_sum[ACC_W-1:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      start_q  <= '0;
      wl_q     <= 32'd1;
      off_q    <= '0;
      cnt      <= '0;
      dcnt     <= 1'b0;
      s2       <= '0;
      acc      <= '0;
      sat      <= 1'b0;
      drop     <= 1'b0;
      err_late <= 1'b0;
      tready_q <= 1'b0;
      for (int i = 0; i < LANES; i++) s1[i] <= '0;
    end else begin
      state    <= nxt;
      tready_q <= 1'b1;
      s1       <= d1;
      s2       <= sum;
      dcnt     <= (state == DRAIN) ? ~dcnt : 1'b0;
      cnt      <= (state == ARMED) ? 32'd1 : (state == ACCUM) ? cnt + 32'd1 : cnt;
      if (arm_ok) begin
        start_q  <= start_time;
        wl_q     <= (window_len == 32'd0) ? 32'd1 : window_len;
        off_q    <= amp_offset;
        acc      <= '0;
        sat      <= 1'b0;
        drop     <= 1'b0;
        err_late <= start_time <= timestamp;
      end else begin
        if (state == ACCUM || state == DRAIN) begin
          acc <= acc_nxt;
          sat <= sat | ovf;
        end
        if (counting && !s_axis_data_tvalid) drop <= 1'b1;
      end
    end
  end

  assign s_axis_data_tready = tready_q;
  assign busy               = state != IDLE;
  assign res_tvalid         = state == OUTPUT;
  assign res_tdata          = 64'(acc);
  assign res_tuser          = {drop, sat};
endmodule

// File: tb/tb_rfdc_adc_integrator.sv
// tb_rfdc_adc_integrator: scoreboard bench running a 48-bit and a 24-bit accumulator instance side by side
// against a per-beat arithmetic model of the windowed integration.
module tb_rfdc_adc_integrator;
  typedef struct {
    logic [63:0] d;
    logic [1:0]  u;
    logic [63:0] t;
  } exp_t;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [255:0] tdata = '0;
  logic         tvalid = 1'b0;
  logic [63:0]  timestamp = 64'h0000_0000_FFFF_FFC0;
  logic [63:0]  start_time = '0;
  logic [31:0]  window_len = '0;
  logic [15:0]  amp_offset = '0;
  logic         arm = 1'b0;
  logic         res_tready = 1'b0;
  logic         tready [2];
  logic         busy [2];
  logic         err_late [2];
  logic [63:0]  rd [2];
  logic [1:0]   ru [2];
  logic         rv [2];

  exp_t sb [2][$];
  int   compared = 0, mismatched = 0;

  bit          fixed = 1'b1;
  logic [15:0] lane_val = '0;
  int          vprob = 100, rprob = 100;
  logic [63:0] bad = '0;
  bit          win_on = 1'b0;
  logic [63:0] win_start = '0;
  int          win_len = 1;
  logic [15:0] win_off = '0;
  longint      acc0, acc1;
  bit          sat0, sat1, drop_m;

  always #5 clk = ~clk;

  rfdc_adc_integrator #(.LANES(16), .SAMPLE_W(16), .ACC_W(48)) dut (
    .clk(clk), .resetn(resetn), .s_axis_data_tdata(tdata), .s_axis_data_tvalid(tvalid),
    .s_axis_data_tready(tready[0]), .timestamp(timestamp), .start_time(start_time),
    .window_len(window_len), .amp_offset(amp_offset), .arm(arm), .busy(busy[0]),
    .err_late(err_late[0]), .res_tdata(rd[0]), .res_tuser(ru[0]), .res_tvalid(rv[0]),
    .res_tready(res_tready));

  rfdc_adc_integrator #(.LANES(16), .SAMPLE_W(16), .ACC_W(24)) dut24 (
    .clk(clk), .resetn(resetn), .s_axis_data_tdata(tdata), .s_axis_data_tvalid(tvalid),
    .s_axis_data_tready(tready[1]), .timestamp(timestamp), .start_time(start_time),
    .window_len(window_len), .amp_offset(amp_offset), .arm(arm), .busy(busy[1]),
    .err_late(err_late[1]), .res_tdata(rd[1]), .res_tuser(ru[1]), .res_tvalid(rv[1]),
    .res_tready(res_tready));

  function automatic void check(string n, logic [63:0] a, logic [63:0] e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endfunction

  function automatic longint beat_sum(logic [255:0] x, logic [15:0] off);
    longint s = 0;
    for (int i = 0; i < 16; i++)
      s += longint'($signed(x[16*i +: 16])) - longint'($signed(off));
    return s;
  endfunction

  function automatic longint clamp(longint v, int w, inout bit sat);
    longint mx = (longint'(1) << (w - 1)) - 1;
    longint mn = -mx - 1;
    if (v > mx) begin sat = 1'b1; return mx; end
    if (v < mn) begin sat = 1'b1; return mn; end
    return v;
  endfunction

  // Monitor: compares every presented result cycle with the scoreboard head.
  bit held [2] = '{1'b0, 1'b0};
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!resetn) held[i] = 1'b0;
      else if (rv[i]) begin
        if (sb[i].size() == 0) begin
          if (!held[i]) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_result[%0d]: got %0h expected none", i, rd[i]);
          end
        end else begin
          check($sformatf("res_tdata[%0d]", i), rd[i], sb[i][0].d);
          check($sformatf("res_tuser[%0d]", i), 64'(ru[i]), 64'(sb[i][0].u));
          if (!held[i]) check($sformatf("latency_ts[%0d]", i), timestamp, sb[i][0].t);
          if (res_tready) void'(sb[i].pop_front());
        end
        held[i] = !res_tready;
      end else held[i] = 1'b0;
    end
  end

  task automatic step();
    bit     in_win, tv;
    longint s;
    int     b;
    @(posedge clk);
    #1;
    arm        = 1'b0;
    timestamp  = timestamp + 64'd1;
    res_tready = $urandom_range(99) < rprob;
    start_time = {$urandom, $urandom};
    window_len = $urandom;
    amp_offset = 16'($urandom);
    for (int k = 0; k < 8; k++) tdata[32*k +: 32] = $urandom;
    if (fixed) for (int k = 0; k < 16; k++) tdata[16*k +: 16] = lane_val;
    in_win = win_on && timestamp >= win_start && timestamp < win_start + 64'(win_len);
    b  = int'(timestamp - win_start);
    tv = in_win ? (!(b < 64 && bad[b]) && $urandom_range(99) < vprob) : 1'($urandom_range(1));
    tvalid = tv;
    if (in_win) begin
      s = tv ? beat_sum(tdata, win_off) : 0;
      if (!tv) drop_m = 1'b1;
      acc0 = clamp(acc0 + s, 48, sat0);
      acc1 = clamp(acc1 + s, 24, sat1);
      if (b == win_len - 1) begin
        sb[0].push_back('{64'(acc0), {drop_m, sat0}, win_start + 64'(win_len) + 64'd2});
        sb[1].push_back('{64'(acc1), {drop_m, sat1}, win_start + 64'(win_len) + 64'd2});
        win_on = 1'b0;
      end
    end
  endtask

  // Called right after step(): pulses arm this cycle and opens the model window.
  task automatic arm_at(int delta, int w, logic [15:0] off);
    arm        = 1'b1;
    start_time = timestamp + 64'(delta);
    window_len = 32'(w);
    amp_offset = off;
    win_on     = 1'b1;
    win_start  = start_time;
    win_len    = (w == 0) ? 1 : w;
    win_off    = off;
    acc0 = 0; acc1 = 0; sat0 = 1'b0; sat1 = 1'b0; drop_m = 1'b0;
  endtask

  task automatic wait_done(string n);
    int k = 0;
    while ((sb[0].size() != 0 || sb[1].size() != 0 || win_on) && k < 400) begin
      step();
      k++;
    end
    check({n, "_drained"}, 64'(sb[0].size() + sb[1].size() + int'(win_on)), 64'd0);
    step();
    step();
    for (int i = 0; i < 2; i++) check({n, "_idle_busy"}, 64'(busy[i]), 64'd0);
  endtask

  initial begin
    repeat (3) step();
    for (int i = 0; i < 2; i++) begin
      check("rst_tready", 64'(tready[i]), 64'd0);
      check("rst_busy", 64'(busy[i]), 64'd0);
      check("rst_tvalid", 64'(rv[i]), 64'd0);
      check("rst_tdata", rd[i], 64'd0);
    end
    resetn = 1'b1;
    step();
    for (int i = 0; i < 2; i++) check("tready_after_rst", 64'(tready[i]), 64'd1);

    lane_val = 16'h0100;
    step(); arm_at(10, 4, 16'h0000); step();
    for (int i = 0; i < 2; i++) check("t1_busy", 64'(busy[i]), 64'd1);
    wait_done("t1");

    lane_val = 16'h0000;
    step(); arm_at(3, 1, 16'h0010); wait_done("t2");

    lane_val = 16'h7FFF;
    step(); arm_at(5, 20, 16'h0000); wait_done("t3");

    step();
    arm = 1'b1; start_time = timestamp - 64'd1; window_len = 32'd4; amp_offset = '0;
    step(); step();
    for (int i = 0; i < 2; i++) begin
      check("t4_err_late", 64'(err_late[i]), 64'd1);
      check("t4_busy", 64'(busy[i]), 64'd0);
    end
    arm = 1'b1; start_time = timestamp; window_len = 32'd4;
    step(); step();
    for (int i = 0; i < 2; i++) check("t4_err_late_eq", 64'(err_late[i]), 64'd1);

    lane_val = 16'h0001; bad = 64'h24;
    step(); arm_at(4, 8, 16'h0000); step();
    for (int i = 0; i < 2; i++) check("t5_err_cleared", 64'(err_late[i]), 64'd0);
    wait_done("t5");
    bad = '0;

    fixed = 1'b0; rprob = 0;
    step(); arm_at(3, 6, 16'($urandom));
    begin
      int k = 0;
      while (!rv[0] && k < 50) begin step(); k++; end
    end
    check("t6_valid", 64'(rv[0]), 64'd1);
    for (int p = 0; p < 5; p++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        check("t6_busy", 64'(busy[i]), 64'd1);
        check("t6_held", 64'(rv[i]), 64'd1);
      end
      arm = 1'b1; start_time = timestamp + 64'd2; window_len = 32'd3;
      if (p == 4) res_tready = 1'b1;
    end
    rprob = 100;
    wait_done("t6");

    fixed = 1'b1; lane_val = 16'h0123;
    step(); arm_at(2, 20, 16'h0000);
    repeat (6) step();
    resetn = 1'b0; win_on = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      check("mid_rst_busy", 64'(busy[i]), 64'd0);
      check("mid_rst_tvalid", 64'(rv[i]), 64'd0);
      check("mid_rst_tdata", rd[i], 64'd0);
      check("mid_rst_tuser", 64'(ru[i]), 64'd0);
      check("mid_rst_tready", 64'(tready[i]), 64'd0);
      check("mid_rst_err", 64'(err_late[i]), 64'd0);
    end
    resetn = 1'b1;
    repeat (30) step();
    for (int i = 0; i < 2; i++) check("post_rst_busy", 64'(busy[i]), 64'd0);

    fixed = 1'b0; vprob = 90; rprob = 60;
    for (int r = 0; r < 12; r++) begin
      step();
      arm_at(int'($urandom_range(1, 6)), int'($urandom_range(0, 12)), 16'($urandom));
      wait_done("rand");
    end
    for (int i = 0; i < 2; i++) check("final_err_late", 64'(err_late[i]), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
